fifo_generator: RTL and testbench

Synchronous single-clock FIFO, 32-bit words, 4 entries, with first-word-fall-through (show-ahead) read data. A producer pushes words with a write strobe and a consumer pops them with a read strobe. Full and Empty status flags guard both sides. It is a generic buffering primitive placed between pipeline stages within one clock domain.

---
 rtl/fifo_generator.sv | 75 +++++++
 tb/tb_fifo_generator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_generator.sv
// Single-clock 4-deep show-ahead FIFO with combinational head-of-queue read data.
// Optional sticky Overflow/Underflow outputs are enabled by defining FIFOGEN_ERR_FLAGS_EN.
module fifo_generator #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  ARES_design_CLK,
   input  logic                  ARES_design_RESET,
   input  logic [DATA_WIDTH-1:0] ARES_design_WData,
   input  logic                  ARES_design_Write,
   output logic                  ARES_design_Full,
   output logic [DATA_WIDTH-1:0] ARES_design_RData,
   input  logic                  ARES_design_Read,
`ifdef FIFOGEN_ERR_FLAGS_EN
   output logic                  ARES_design_Overflow,
   output logic                  ARES_design_Underflow,
`endif
   output logic                  ARES_design_Empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic                  push;
   logic                  pop;

   // Flags come only from the count register, so strobes never reach outputs.
   assign ARES_design_Empty = (count == '0);
   assign ARES_design_Full  = (count == (AW+1)'(DEPTH));
   assign ARES_design_RData = ARES_design_Empty ? '0 : mem[rd_ptr];

   assign push = ARES_design_Write & ~ARES_design_Full;
   assign pop  = ARES_design_Read  & ~ARES_design_Empty;

   always_ff @(posedge ARES_design_CLK) begin
      if (push)
         mem[wr_ptr] <= ARES_design_WData;
   end

   always_ff @(posedge ARES_design_CLK or negedge ARES_design_RESET) begin
      if (!ARES_design_RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef FIFOGEN_ERR_FLAGS_EN
   always_ff @(posedge ARES_design_CLK or negedge ARES_design_RESET) begin
      if (!ARES_design_RESET) begin
         ARES_design_Overflow  <= 1'b0;
         ARES_design_Underflow <= 1'b0;
      end else begin
         if (ARES_design_Write && ARES_design_Full)
            ARES_design_Overflow <= 1'b1;
         if (ARES_design_Read && ARES_design_Empty)
            ARES_design_Underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_generator.sv
// Directed self-checking bench for fifo_generator; covers error flags when
// FIFOGEN_ERR_FLAGS_EN is defined.
module tb_fifo_generator;

   logic        clk;
   logic        rst_n;
   logic [31:0] wdata;
   logic        wr;
   logic        rd;
   logic        full;
   logic        empty;
   logic [31:0] rdata;
`ifdef FIFOGEN_ERR_FLAGS_EN
   logic        ovf;
   logic        udf;
`endif

   int checks = 0;
   int errors = 0;

   fifo_generator #(.DATA_WIDTH(32), .DEPTH(4)) dut (
      .ARES_design_CLK      (clk),
      .ARES_design_RESET    (rst_n),
      .ARES_design_WData    (wdata),
      .ARES_design_Write    (wr),
      .ARES_design_Full     (full),
      .ARES_design_RData    (rdata),
      .ARES_design_Read     (rd),
`ifdef FIFOGEN_ERR_FLAGS_EN
      .ARES_design_Overflow (ovf),
      .ARES_design_Underflow(udf),
`endif
      .ARES_design_Empty    (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr = 1'b0; rd = 1'b0; wdata = '0;
      #12;
      rst_n = 1'b1;
      step();
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: empty=%b full=%b rdata=%0d, want 1 0 0", empty, full, rdata);
      end
`ifdef FIFOGEN_ERR_FLAGS_EN
      checks++;
      if (ovf !== 1'b0 || udf !== 1'b0) begin
         errors++;
         $display("FAIL reset_errflags: ovf=%b udf=%b, want 0 0", ovf, udf);
      end
`endif
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         wr = 1'b1; wdata = 32'd15 + i;
         step();
         checks++;
         if (empty !== 1'b0 || full !== (i == 3) || rdata !== 32'd15) begin
            errors++;
            $display("FAIL fill_%0d: empty=%b full=%b rdata=%0d, want 0 %b 15", i, empty, full, rdata, (i == 3));
         end
      end
      wr = 1'b0;
   endtask

   task automatic test_drain();
      logic [31:0] exp_rd;
      for (int i = 0; i < 4; i++) begin
         rd = 1'b1;
         step();
         exp_rd = (i == 3) ? 32'd0 : 32'd16 + i;
         checks++;
         if (full !== 1'b0 || empty !== (i == 3) || rdata !== exp_rd) begin
            errors++;
            $display("FAIL drain_%0d: full=%b empty=%b rdata=%0d, want 0 %b %0d", i, full, empty, rdata, (i == 3), exp_rd);
         end
      end
      rd = 1'b0;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) begin
         wr = 1'b1; wdata = 32'd15 + i;
         step();
      end
      wdata = 32'd99;
      step();
      wr = 1'b0;
      checks++;
      if (full !== 1'b1 || rdata !== 32'd15) begin
         errors++;
         $display("FAIL overflow_drop: full=%b rdata=%0d, want 1 15", full, rdata);
      end
`ifdef FIFOGEN_ERR_FLAGS_EN
      checks++;
      if (ovf !== 1'b1 || udf !== 1'b0) begin
         errors++;
         $display("FAIL overflow_flag: ovf=%b udf=%b, want 1 0", ovf, udf);
      end
`endif
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rdata !== 32'd15 + i) begin
            errors++;
            $display("FAIL overflow_read_%0d: rdata=%0d, want %0d", i, rdata, 32'd15 + i);
         end
         rd = 1'b1;
         step();
      end
      rd = 1'b0;
      checks++;
      if (empty !== 1'b1 || rdata !== 32'd0) begin
         errors++;
         $display("FAIL overflow_empty: empty=%b rdata=%0d, want 1 0", empty, rdata);
      end
   endtask

   task automatic test_simul();
      logic [31:0] exp_seq [8];
      exp_seq = '{32'd100, 32'd200, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
      wr = 1'b1; wdata = 32'd100;
      step();
      wdata = 32'd200;
      step();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (rdata !== exp_seq[i]) begin
            errors++;
            $display("FAIL simul_head_%0d: rdata=%0d, want %0d", i, rdata, exp_seq[i]);
         end
         wr = 1'b1; rd = 1'b1; wdata = 32'd1 + i;
         step();
         checks++;
         if (empty !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL simul_count_%0d: empty=%b full=%b, want 0 0", i, empty, full);
         end
      end
      wr = 1'b0;
      for (int i = 6; i < 8; i++) begin
         checks++;
         if (rdata !== exp_seq[i]) begin
            errors++;
            $display("FAIL simul_tail_%0d: rdata=%0d, want %0d", i, rdata, exp_seq[i]);
         end
         rd = 1'b1;
         step();
      end
      rd = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL simul_empty: empty=%b, want 1", empty);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         wr = 1'b1; wdata = 32'd7 + i;
         step();
      end
      wr = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || rdata !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: empty=%b full=%b rdata=%0d, want 1 0 0", empty, full, rdata);
      end
`ifdef FIFOGEN_ERR_FLAGS_EN
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_ovf: ovf=%b, want 0", ovf);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      rd = 1'b1;
      step();
      rd = 1'b0;
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || rdata !== 32'd0) begin
         errors++;
         $display("FAIL underflow_ignored: empty=%b full=%b rdata=%0d, want 1 0 0", empty, full, rdata);
      end
`ifdef FIFOGEN_ERR_FLAGS_EN
      checks++;
      if (udf !== 1'b1) begin
         errors++;
         $display("FAIL underflow_flag: udf=%b, want 1", udf);
      end
`endif
      wr = 1'b1; wdata = 32'd42;
      step();
      wr = 1'b0;
      checks++;
      if (empty !== 1'b0 || rdata !== 32'd42) begin
         errors++;
         $display("FAIL post_reset_push: empty=%b rdata=%0d, want 0 42", empty, rdata);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_overflow();
      test_simul();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
